// File: rtl/exe_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : exe_cmd_issuer
// Brief    : Buffers command packets, issues them to the execution unit under
//            response-FIFO credit, and returns tagged results in issue order.
// Revision : 1.0
// ============================================================================
module exe_cmd_issuer #(
  parameter int WIDTH     = 32,
  parameter int OPER_W    = 4,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int EXE_LAT   = 1,
  parameter int TAG_W     = 4
) (
  input  logic              i_clk,
  input  logic              i_rsn,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [OPER_W-1:0] i_cmd_oper,
  input  logic [WIDTH-1:0]  i_cmd_argA,
  input  logic [WIDTH-1:0]  i_cmd_argB,
  output logic              o_exe_valid,
  output logic [OPER_W-1:0] o_exe_oper,
  output logic [WIDTH-1:0]  o_exe_argA,
  output logic [WIDTH-1:0]  o_exe_argB,
  input  logic [WIDTH-1:0]  i_exe_result,
  input  logic [3:0]        i_exe_status,
  input  logic              i_exe_error,
  input  logic              i_exe_carry,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [WIDTH-1:0]  o_rsp_result,
  output logic [3:0]        o_rsp_status,
  output logic              o_rsp_error,
  output logic              o_rsp_carry,
  output logic [TAG_W-1:0]  o_rsp_tag,
  output logic              o_busy
);

  localparam int c_cmd_aw = $clog2(CMD_DEPTH);
  localparam int c_cmd_cw = c_cmd_aw + 1;
  localparam int c_rsp_aw = $clog2(RSP_DEPTH);
  localparam int c_rsp_cw = c_rsp_aw + 1;
  localparam int c_inf_w  = $clog2(EXE_LAT + 2) + 1;
  localparam int c_sum_w  = c_rsp_cw + c_inf_w;

  // Command FIFO
  logic [OPER_W-1:0]   r_cmd_oper [CMD_DEPTH];
  logic [WIDTH-1:0]    r_cmd_arga [CMD_DEPTH];
  logic [WIDTH-1:0]    r_cmd_argb [CMD_DEPTH];
  logic [c_cmd_aw-1:0] r_cmd_wptr;
  logic [c_cmd_aw-1:0] r_cmd_rptr;
  logic [c_cmd_cw-1:0] r_cmd_count;

  // Issue register and tag pipe
  logic                r_exe_valid;
  logic [OPER_W-1:0]   r_exe_oper;
  logic [WIDTH-1:0]    r_exe_arga;
  logic [WIDTH-1:0]    r_exe_argb;
  logic [TAG_W-1:0]    r_exe_tag;
  logic [TAG_W-1:0]    r_tag;
  logic [EXE_LAT-1:0]  r_pipe_valid;
  logic [TAG_W-1:0]    r_pipe_tag [EXE_LAT];

  // Response FIFO
  logic [WIDTH-1:0]    r_rsp_result [RSP_DEPTH];
  logic [3:0]          r_rsp_status [RSP_DEPTH];
  logic                r_rsp_error  [RSP_DEPTH];
  logic                r_rsp_carry  [RSP_DEPTH];
  logic [TAG_W-1:0]    r_rsp_tag    [RSP_DEPTH];
  logic [c_rsp_aw-1:0] r_rsp_wptr;
  logic [c_rsp_aw-1:0] r_rsp_rptr;
  logic [c_rsp_cw-1:0] r_rsp_count;

  logic                w_cmd_full;
  logic                w_cmd_push;
  logic                w_issue;
  logic                w_rsp_push;
  logic                w_rsp_pop;
  logic [c_inf_w-1:0]  w_inflight;
  logic [c_sum_w-1:0]  w_credit_used;

  assign w_cmd_full = (r_cmd_count == c_cmd_cw'(CMD_DEPTH));
  assign w_cmd_push = i_cmd_valid & ~w_cmd_full;
  assign w_rsp_push = r_pipe_valid[EXE_LAT-1];
  assign w_rsp_pop  = (r_rsp_count != '0) & i_rsp_ready;

  always_comb begin
    w_inflight = c_inf_w'(r_exe_valid);
    for (int i = 0; i < EXE_LAT; i++) begin
      w_inflight = w_inflight + c_inf_w'(r_pipe_valid[i]);
    end
  end

  // A slot freed by this cycle's response pop may be reused by this cycle's issue.
  assign w_credit_used = c_sum_w'(r_rsp_count) - c_sum_w'(w_rsp_pop) + c_sum_w'(w_inflight);
  assign w_issue       = (r_cmd_count != '0) & (w_credit_used < c_sum_w'(RSP_DEPTH));

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      for (int i = 0; i < CMD_DEPTH; i++) begin
        r_cmd_oper[i] <= '0;
        r_cmd_arga[i] <= '0;
        r_cmd_argb[i] <= '0;
      end
      r_cmd_wptr   <= '0;
      r_cmd_rptr   <= '0;
      r_cmd_count  <= '0;
      r_exe_valid  <= 1'b0;
      r_exe_oper   <= '0;
      r_exe_arga   <= '0;
      r_exe_argb   <= '0;
      r_exe_tag    <= '0;
      r_tag        <= '0;
      r_pipe_valid <= '0;
      for (int i = 0; i < EXE_LAT; i++) begin
        r_pipe_tag[i] <= '0;
      end
      for (int i = 0; i < RSP_DEPTH; i++) begin
        r_rsp_result[i] <= '0;
        r_rsp_status[i] <= '0;
        r_rsp_error[i]  <= 1'b0;
        r_rsp_carry[i]  <= 1'b0;
        r_rsp_tag[i]    <= '0;
      end
      r_rsp_wptr   <= '0;
      r_rsp_rptr   <= '0;
      r_rsp_count  <= '0;
    end else begin
      if (w_cmd_push) begin
        r_cmd_oper[r_cmd_wptr] <= i_cmd_oper;
        r_cmd_arga[r_cmd_wptr] <= i_cmd_argA;
        r_cmd_argb[r_cmd_wptr] <= i_cmd_argB;
        r_cmd_wptr             <= r_cmd_wptr + c_cmd_aw'(1);
      end

      r_exe_valid <= w_issue;
      if (w_issue) begin
        r_exe_oper <= r_cmd_oper[r_cmd_rptr];
        r_exe_arga <= r_cmd_arga[r_cmd_rptr];
        r_exe_argb <= r_cmd_argb[r_cmd_rptr];
        r_exe_tag  <= r_tag;
        r_tag      <= r_tag + TAG_W'(1);
        r_cmd_rptr <= r_cmd_rptr + c_cmd_aw'(1);
      end

      case ({w_cmd_push, w_issue})
        2'b10:   r_cmd_count <= r_cmd_count + c_cmd_cw'(1);
        2'b01:   r_cmd_count <= r_cmd_count - c_cmd_cw'(1);
        default: r_cmd_count <= r_cmd_count;
      endcase

      r_pipe_valid[0] <= r_exe_valid;
      r_pipe_tag[0]   <= r_exe_tag;
      for (int i = 1; i < EXE_LAT; i++) begin
        r_pipe_valid[i] <= r_pipe_valid[i-1];
        r_pipe_tag[i]   <= r_pipe_tag[i-1];
      end

      // Execution-unit outputs are only meaningful when the last pipe stage is valid.
      if (w_rsp_push) begin
        r_rsp_result[r_rsp_wptr] <= i_exe_result;
        r_rsp_status[r_rsp_wptr] <= i_exe_status;
        r_rsp_error[r_rsp_wptr]  <= i_exe_error;
        r_rsp_carry[r_rsp_wptr]  <= i_exe_carry;
        r_rsp_tag[r_rsp_wptr]    <= r_pipe_tag[EXE_LAT-1];
        r_rsp_wptr               <= r_rsp_wptr + c_rsp_aw'(1);
      end
      if (w_rsp_pop) begin
        r_rsp_rptr <= r_rsp_rptr + c_rsp_aw'(1);
      end

      case ({w_rsp_push, w_rsp_pop})
        2'b10:   r_rsp_count <= r_rsp_count + c_rsp_cw'(1);
        2'b01:   r_rsp_count <= r_rsp_count - c_rsp_cw'(1);
        default: r_rsp_count <= r_rsp_count;
      endcase
    end
  end

  assign o_cmd_ready  = ~w_cmd_full;
  assign o_exe_valid  = r_exe_valid;
  assign o_exe_oper   = r_exe_oper;
  assign o_exe_argA   = r_exe_arga;
  assign o_exe_argB   = r_exe_argb;
  assign o_rsp_valid  = (r_rsp_count != '0);
  assign o_rsp_result = r_rsp_result[r_rsp_rptr];
  assign o_rsp_status = r_rsp_status[r_rsp_rptr];
  assign o_rsp_error  = r_rsp_error[r_rsp_rptr];
  assign o_rsp_carry  = r_rsp_carry[r_rsp_rptr];
  assign o_rsp_tag    = r_rsp_tag[r_rsp_rptr];
  assign o_busy       = (r_cmd_count != '0) | (w_inflight != '0) | (r_rsp_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_exe_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_cmd_issuer
// Brief    : Randomized bench for exe_cmd_issuer with a registered exe stub
//            and an in-order response scoreboard.
// Revision : 1.0
// ============================================================================
module tb_exe_cmd_issuer;

  localparam int WIDTH  = 32;
  localparam int OPER_W = 4;
  localparam int TAG_W  = 4;

  logic              i_clk = 1'b0;
  logic              i_rsn = 1'b0;
  logic              i_cmd_valid = 1'b0;
  logic              o_cmd_ready;
  logic [OPER_W-1:0] i_cmd_oper = '0;
  logic [WIDTH-1:0]  i_cmd_argA = '0;
  logic [WIDTH-1:0]  i_cmd_argB = '0;
  logic              o_exe_valid;
  logic [OPER_W-1:0] o_exe_oper;
  logic [WIDTH-1:0]  o_exe_argA;
  logic [WIDTH-1:0]  o_exe_argB;
  logic [WIDTH-1:0]  i_exe_result = '0;
  logic [3:0]        i_exe_status = '0;
  logic              i_exe_error = 1'b0;
  logic              i_exe_carry = 1'b0;
  logic              o_rsp_valid;
  logic              i_rsp_ready = 1'b0;
  logic [WIDTH-1:0]  o_rsp_result;
  logic [3:0]        o_rsp_status;
  logic              o_rsp_error;
  logic              o_rsp_carry;
  logic [TAG_W-1:0]  o_rsp_tag;
  logic              o_busy;

  exe_cmd_issuer #(
    .WIDTH(WIDTH), .OPER_W(OPER_W), .CMD_DEPTH(4), .RSP_DEPTH(4),
    .EXE_LAT(1), .TAG_W(TAG_W)
  ) u_dut (
    .i_clk(i_clk), .i_rsn(i_rsn),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_oper(i_cmd_oper), .i_cmd_argA(i_cmd_argA), .i_cmd_argB(i_cmd_argB),
    .o_exe_valid(o_exe_valid), .o_exe_oper(o_exe_oper),
    .o_exe_argA(o_exe_argA), .o_exe_argB(o_exe_argB),
    .i_exe_result(i_exe_result), .i_exe_status(i_exe_status),
    .i_exe_error(i_exe_error), .i_exe_carry(i_exe_carry),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_result(o_rsp_result), .o_rsp_status(o_rsp_status),
    .o_rsp_error(o_rsp_error), .o_rsp_carry(o_rsp_carry),
    .o_rsp_tag(o_rsp_tag), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_acc    = 0;
  logic [41:0]      exp_q[$];
  int               pop_log[$];
  logic [TAG_W-1:0] tag_log[$];
  logic [41:0]      rsp_obs;
  logic             prev_stall = 1'b0;
  logic [41:0]      prev_data  = '0;

  assign rsp_obs = {o_rsp_result, o_rsp_status, o_rsp_error, o_rsp_carry, o_rsp_tag};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Execution-unit behaviour: {result, status, error, carry}; unknown opcodes give 0.
  function automatic logic [37:0] exe_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] s;
    logic [37:0] r;
    r = '0;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      4'd0:    r = {s[31:0], (s[32] ? 4'hA : 4'h1), s[32], s[32]};
      4'd1:    r = {a ^ b, 4'h2, 2'b00};
      4'd2:    r = {a & b, 4'h3, 2'b00};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Registered stub; drives junk whenever no result is due.
  always @(posedge i_clk) begin
    if (o_exe_valid) begin
      {i_exe_result, i_exe_status, i_exe_error, i_exe_carry} <=
        exe_ref(o_exe_oper, o_exe_argA, o_exe_argB);
    end else begin
      i_exe_result <= $urandom;
      i_exe_status <= 4'($urandom);
      i_exe_error  <= 1'($urandom);
      i_exe_carry  <= 1'($urandom);
    end
  end

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  // Scoreboard: handshakes seen at the negedge complete at the next rising edge.
  initial forever begin
    @(negedge i_clk);
    if (!i_rsn) begin
      exp_q.delete();
      n_acc      = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("rsp_hold", {o_rsp_valid, rsp_obs}, {1'b1, prev_data});
      prev_stall = o_rsp_valid && !i_rsp_ready;
      prev_data  = rsp_obs;
      if (o_rsp_valid && i_rsp_ready) begin
        check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("rsp_data", 64'(rsp_obs), 64'(exp_q.pop_front()));
        pop_log.push_back(cyc + 1);
        tag_log.push_back(o_rsp_tag);
      end
      if (i_cmd_valid && o_cmd_ready) begin
        exp_q.push_back({exe_ref(i_cmd_oper, i_cmd_argA, i_cmd_argB), TAG_W'(n_acc % 16)});
        n_acc++;
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_one(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic acc;
    int   k;
    i_cmd_valid = 1'b1;
    i_cmd_oper  = op;
    i_cmd_argA  = a;
    i_cmd_argB  = b;
    k = 0;
    do begin
      acc = o_cmd_ready;
      tick();
      k++;
    end while (!acc && k < 200);
    check("cmd_accept", 64'(acc), 64'd1);
  endtask

  task automatic send_rand();
    send_one(4'($urandom_range(0, 4)), $urandom, $urandom);
  endtask

  task automatic wait_rsp();
    int k;
    k = 0;
    while (!o_rsp_valid && k < 50) begin
      tick();
      k++;
    end
    check("rsp_wait", 64'(o_rsp_valid), 64'd1);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || o_busy) && k < budget) begin
      tick();
      k++;
    end
    check("drain_q", 64'(exp_q.size()), 64'd0);
    check("drain_busy", 64'(o_busy), 64'd0);
  endtask

  task automatic pulse_reset();
    i_rsn = 1'b0;
    tick();
    i_rsn = 1'b1;
    tick();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cmd_ready"}, 64'(o_cmd_ready), 64'd1);
    check({pfx, "_exe_valid"}, 64'(o_exe_valid), 64'd0);
    check({pfx, "_exe_oper"}, 64'(o_exe_oper), 64'd0);
    check({pfx, "_exe_argA"}, 64'(o_exe_argA), 64'd0);
    check({pfx, "_exe_argB"}, 64'(o_exe_argB), 64'd0);
    check({pfx, "_rsp_valid"}, 64'(o_rsp_valid), 64'd0);
    check({pfx, "_rsp_data"}, 64'(rsp_obs), 64'd0);
    check({pfx, "_busy"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycles %0d, limit reached)", cyc);
    $fatal(1);
  end

  initial begin
    int  acc_edge;
    bit  drv_done;

    repeat (2) tick();
    check_reset_outputs("reset");
    i_rsn = 1'b1;
    tick();

    // Single op: 5+7, 3 cycles from accept to valid response, consumed one edge later
    i_rsp_ready = 1'b1;
    pop_log.delete();
    tag_log.delete();
    i_cmd_valid = 1'b1; i_cmd_oper = 4'd0; i_cmd_argA = 32'd5; i_cmd_argB = 32'd7;
    tick();
    acc_edge = cyc;
    i_cmd_valid = 1'b0;
    check("single_exe_pre", 64'(o_exe_valid), 64'd0);
    check("single_busy", 64'(o_busy), 64'd1);
    tick();
    check("single_exe_valid", 64'(o_exe_valid), 64'd1);
    check("single_exe_args", {o_exe_argA, o_exe_argB}, {32'd5, 32'd7});
    tick();
    check("single_exe_1cyc", 64'(o_exe_valid), 64'd0);
    check("single_rsp_early", 64'(o_rsp_valid), 64'd0);
    tick();
    check("single_rsp_valid", 64'(o_rsp_valid), 64'd1);
    check("single_result", 64'(o_rsp_result), 64'd12);
    check("single_tag", 64'(o_rsp_tag), 64'd0);
    wait_drain(20);
    check("single_pops", 64'(pop_log.size()), 64'd1);
    if (pop_log.size() == 1) check("single_latency", 64'(pop_log[0] - acc_edge), 64'd4);

    // Flag pass-through on an overflowing add
    send_one(4'd0, 32'hFFFF_FFFF, 32'd1);
    i_cmd_valid = 1'b0;
    wait_rsp();
    check("flags_result", 64'(o_rsp_result), 64'd0);
    check("flags_status", 64'(o_rsp_status), 64'hA);
    check("flags_err_carry", {o_rsp_error, o_rsp_carry}, 64'b11);
    wait_drain(20);

    // Streaming: 20 back-to-back commands, tags wrap at the 17th response
    pulse_reset();
    pop_log.delete();
    tag_log.delete();
    send_rand();
    acc_edge = cyc;
    for (int i = 1; i < 20; i++) send_rand();
    i_cmd_valid = 1'b0;
    check("stream_accept_span", 64'(cyc - acc_edge), 64'd19);
    wait_drain(100);
    check("stream_pops", 64'(pop_log.size()), 64'd20);
    if (pop_log.size() == 20) begin
      check("stream_first", 64'(pop_log[0] - acc_edge), 64'd4);
      check("stream_rate", 64'(pop_log[19] - pop_log[0]), 64'd19);
      check("stream_tag15", 64'(tag_log[15]), 64'd15);
      check("stream_tag_wrap", 64'(tag_log[16]), 64'd0);
    end

    // Backpressure, then a single-cycle release with the cmd FIFO full
    pulse_reset();
    pop_log.delete();
    tag_log.delete();
    i_rsp_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send_rand();
        i_cmd_valid = 1'b0;
      end
      begin
        repeat (12) tick();
        check("bp_cmd_ready", 64'(o_cmd_ready), 64'd0);
        check("bp_issue_stall", 64'(o_exe_valid), 64'd0);
        check("bp_accepted", 64'(exp_q.size()), 64'd8);
        check("bp_rsp_valid", 64'(o_rsp_valid), 64'd1);
        if (exp_q.size() != 0) check("bp_head", 64'(rsp_obs), 64'(exp_q[0]));
        tick();
        check("bp_head_tag", 64'(o_rsp_tag), 64'd0);
        i_rsp_ready = 1'b1;
        check("full_ready_same", 64'(o_cmd_ready), 64'd0);
        tick();
        i_rsp_ready = 1'b0;
        check("full_ready_next", 64'(o_cmd_ready), 64'd1);
        check("full_issue", 64'(o_exe_valid), 64'd1);
        check("full_pop_tag", 64'(o_rsp_tag), 64'd1);
        repeat (3) tick();
        i_rsp_ready = 1'b1;
      end
    join
    wait_drain(100);
    check("bp_pops", 64'(pop_log.size()), 64'd10);
    for (int i = 0; i < 10 && i < tag_log.size(); i++) check("bp_order", 64'(tag_log[i]), 64'(i));

    // Random traffic with random consumer backpressure
    pop_log.delete();
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send_rand();
          i_cmd_valid = 1'b0;
          repeat ($urandom_range(0, 2)) tick();
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          i_rsp_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    i_rsp_ready = 1'b1;
    wait_drain(300);
    check("rand_pops", 64'(pop_log.size()), 64'd40);

    // Reset with operations in flight
    send_rand();
    send_rand();
    send_rand();
    i_cmd_valid = 1'b0;
    check("mid_busy", 64'(o_busy), 64'd1);
    i_rsn = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    i_rsn = 1'b1;
    pop_log.delete();
    repeat (5) tick();
    check("mid_no_stale", 64'(pop_log.size()), 64'd0);
    check("mid_no_issue", {o_exe_valid, o_rsp_valid}, 64'd0);
    send_one(4'd0, 32'd3, 32'd4);
    i_cmd_valid = 1'b0;
    wait_rsp();
    check("mid_new_tag", 64'(o_rsp_tag), 64'd0);
    check("mid_new_result", 64'(o_rsp_result), 64'd7);
    wait_drain(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
